// File: rtl/oto_pilot_pkg.sv
// Shared types, constants and helpers for the line-following autopilot.
// State encoding, default parameters, popcount and duty saturation.
package oto_pilot_pkg;

    localparam int SENS_W_DEF       = 16;
    localparam int PWM_W_DEF        = 8;
    localparam int DEB_CYC_DEF      = 4;
    localparam int LOST_TIMEOUT_DEF = 1000;
    localparam int BASE_DUTY_DEF    = 128;
    localparam int GAIN_DEF         = 8;
    localparam int LOST_CNT_W       = 20;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_LOST    = 2'd2,
        ST_BLOCKED = 2'd3
    } pilot_state_e;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

    // Clamp a signed value into 0..max_v.
    function automatic logic [31:0] sat_duty(input logic signed [31:0] v,
                                             input logic [31:0] max_v);
        if (v < 0) begin
            return '0;
        end else if ($unsigned(v) > max_v) begin
            return max_v;
        end else begin
            return $unsigned(v);
        end
    endfunction

endpackage

// File: rtl/oto_pilot_debounce.sv
// Two-flop synchroniser plus per-bit debounce for a WIDTH-bit bus.
// Ports: clock, reset (async, active-low), din (raw), dout (filtered).
module oto_pilot_debounce #(
    parameter int WIDTH   = 1,
    parameter int DEB_CYC = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int CW = 4;

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic          filt;
        logic [CW-1:0] cnt;

        // Counter tracks consecutive samples differing from filt;
        // the DEB_CYC-th such sample commits the new level.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                filt <= 1'b0;
                cnt  <= '0;
            end else if (s2[i] == filt) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYC - 1)) begin
                filt <= s2[i];
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end

        assign dout[i] = filt;
    end

endmodule

// File: rtl/oto_pilot_pwm.sv
// Line-following autopilot: conditioned inputs, steering error, FSM, PWM.
// Ports: clock, reset, sens_in, obst/start/stop_in, pwm_l/r, state_o, out_oeb.
module oto_pilot_pwm
    import oto_pilot_pkg::*;
#(
    parameter int SENS_W       = SENS_W_DEF,
    parameter int PWM_W        = PWM_W_DEF,
    parameter int DEB_CYC      = DEB_CYC_DEF,
    parameter int LOST_TIMEOUT = LOST_TIMEOUT_DEF,
    parameter int BASE_DUTY    = BASE_DUTY_DEF,
    parameter int GAIN         = GAIN_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [SENS_W-1:0] sens_in,
    input  logic              obst_in,
    input  logic              start_in,
    input  logic              stop_in,
    output logic              pwm_l,
    output logic              pwm_r,
    output logic [1:0]        state_o,
    output logic [2:0]        out_oeb
);

    localparam int HALF   = SENS_W / 2;
    localparam int EW     = $clog2(SENS_W) + 2;
    localparam int CALC_W = PWM_W + $clog2(SENS_W) + $clog2(GAIN) + 2;

    localparam logic [31:0] PMAX32 = 32'((1 << PWM_W) - 1);
    localparam logic [PWM_W-1:0] PMAX = PWM_W'((1 << PWM_W) - 1);
    localparam logic [PWM_W-1:0] BASE = PWM_W'(BASE_DUTY);
    localparam logic signed [CALC_W-1:0] BASE_S = CALC_W'(BASE_DUTY);
    localparam logic signed [CALC_W-1:0] GAIN_S = CALC_W'(GAIN);
    localparam logic [LOST_CNT_W-1:0] LOST_LAST =
        LOST_CNT_W'(LOST_TIMEOUT - 1);

    logic [SENS_W-1:0] sens_f;
    logic [2:0]        ctrl_f;
    logic              obst_f;
    logic              start_f;
    logic              stop_f;
    logic              any_sens;

    oto_pilot_debounce #(.WIDTH(SENS_W), .DEB_CYC(DEB_CYC)) u_deb_sens (
        .clock (clock),
        .reset (reset),
        .din   (sens_in),
        .dout  (sens_f)
    );

    oto_pilot_debounce #(.WIDTH(3), .DEB_CYC(DEB_CYC)) u_deb_ctrl (
        .clock (clock),
        .reset (reset),
        .din   ({obst_in, start_in, stop_in}),
        .dout  (ctrl_f)
    );

    assign obst_f   = ctrl_f[2];
    assign start_f  = ctrl_f[1];
    assign stop_f   = ctrl_f[0];
    assign any_sens = |sens_f;

    // Steering error: left half minus right half
    logic [5:0]           pop_u;
    logic [5:0]           pop_l;
    logic signed [EW-1:0] err_d;
    logic signed [EW-1:0] err_q;
    logic signed [EW-1:0] last_err;

    assign pop_u = popcount32(32'(sens_f[SENS_W-1:HALF]));
    assign pop_l = popcount32(32'(sens_f[HALF-1:0]));
    assign err_d = $signed(EW'(pop_u)) - $signed(EW'(pop_l));

    // Steering targets, computed wide enough that clamping sees the true value
    logic signed [CALC_W-1:0] err_s;
    logic signed [CALC_W-1:0] prod;
    logic signed [CALC_W-1:0] diff_l;
    logic signed [CALC_W-1:0] diff_r;
    logic [PWM_W-1:0]         tgt_l;
    logic [PWM_W-1:0]         tgt_r;

    assign err_s  = {{(CALC_W-EW){err_q[EW-1]}}, err_q};
    assign prod   = GAIN_S * err_s;
    assign diff_l = BASE_S - prod;
    assign diff_r = BASE_S + prod;
    assign tgt_l  = PWM_W'(sat_duty({{(32-CALC_W){diff_l[CALC_W-1]}}, diff_l},
                                    PMAX32));
    assign tgt_r  = PWM_W'(sat_duty({{(32-CALC_W){diff_r[CALC_W-1]}}, diff_r},
                                    PMAX32));

    // Sequencing FSM
    pilot_state_e          state_q;
    pilot_state_e          state_d;
    logic                  lost_clr;
    logic [LOST_CNT_W-1:0] lost_cnt;
    logic [PWM_W-1:0]      sel_l;
    logic [PWM_W-1:0]      sel_r;

    always_comb begin
        state_d  = state_q;
        lost_clr = 1'b0;
        sel_l    = '0;
        sel_r    = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (!stop_f && start_f) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                sel_l = tgt_l;
                sel_r = tgt_r;
                if (stop_f) begin
                    state_d = ST_IDLE;
                end else if (obst_f) begin
                    state_d = ST_BLOCKED;
                end else if (!any_sens) begin
                    state_d  = ST_LOST;
                    lost_clr = 1'b1;
                end
            end
            ST_LOST: begin
                // Pivot toward the side where the line was last seen
                if (last_err >= 0) begin
                    sel_r = BASE;
                end else begin
                    sel_l = BASE;
                end
                if (stop_f) begin
                    state_d = ST_IDLE;
                end else if (obst_f) begin
                    state_d = ST_BLOCKED;
                end else if (any_sens) begin
                    state_d = ST_RUN;
                end else if (lost_cnt == LOST_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BLOCKED: begin
                if (stop_f) begin
                    state_d = ST_IDLE;
                end else if (!obst_f) begin
                    if (any_sens) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d  = ST_LOST;
                        lost_clr = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            err_q    <= '0;
            last_err <= '0;
            lost_cnt <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (state_q == ST_RUN) begin
                last_err <= err_q;
            end
            if (lost_clr) begin
                lost_cnt <= '0;
            end else if (state_q == ST_LOST) begin
                lost_cnt <= lost_cnt + LOST_CNT_W'(1);
            end
        end
    end

    // PWM: duties only change at the period wrap
    logic [PWM_W-1:0] cnt;
    logic [PWM_W-1:0] duty_l;
    logic [PWM_W-1:0] duty_r;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            duty_l  <= '0;
            duty_r  <= '0;
            pwm_l   <= 1'b0;
            pwm_r   <= 1'b0;
            out_oeb <= 3'b111;
        end else begin
            cnt     <= cnt + PWM_W'(1);
            pwm_l   <= (cnt < duty_l);
            pwm_r   <= (cnt < duty_r);
            out_oeb <= 3'b000;
            if (cnt == PMAX) begin
                duty_l <= sel_l;
                duty_r <= sel_r;
            end
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_oto_pilot_pwm.sv
// Self-checking bench for oto_pilot_pwm (default gain and GAIN=32).
// Duties are measured as high-cycle counts over one full PWM period.
module tb_oto_pilot_pwm;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] sens_in = '0;
    logic        obst_in = 1'b0;
    logic        start_in = 1'b0;
    logic        stop_in = 1'b0;

    logic       pwm_l, pwm_r, g_pwm_l, g_pwm_r;
    logic [1:0] state_o, g_state;
    logic [2:0] out_oeb, g_oeb;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    oto_pilot_pwm dut (
        .clock    (clock),
        .reset    (reset),
        .sens_in  (sens_in),
        .obst_in  (obst_in),
        .start_in (start_in),
        .stop_in  (stop_in),
        .pwm_l    (pwm_l),
        .pwm_r    (pwm_r),
        .state_o  (state_o),
        .out_oeb  (out_oeb)
    );

    oto_pilot_pwm #(.GAIN(32)) dut_g (
        .clock    (clock),
        .reset    (reset),
        .sens_in  (sens_in),
        .obst_in  (obst_in),
        .start_in (start_in),
        .stop_in  (stop_in),
        .pwm_l    (g_pwm_l),
        .pwm_r    (g_pwm_r),
        .state_o  (g_state),
        .out_oeb  (g_oeb)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_err(input logic [15:0] s);
        int u, l;
        u = 0;
        l = 0;
        for (int i = 8; i < 16; i++) u += int'(s[i]);
        for (int i = 0; i < 8; i++) l += int'(s[i]);
        return u - l;
    endfunction

    function automatic int ref_duty(input int gain, input int e, input int sgn);
        int v;
        v = 128 + sgn * gain * e;
        if (v < 0) v = 0;
        if (v > 255) v = 255;
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic measure(output int hl, output int hr,
                           output int gl, output int gr);
        hl = 0; hr = 0; gl = 0; gr = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clock);
            hl += int'(pwm_l);
            hr += int'(pwm_r);
            gl += int'(g_pwm_l);
            gr += int'(g_pwm_r);
        end
    endtask

    task automatic settle_check(input string tag, input int el, input int er,
                                input int egl, input int egr);
        int hl, hr, gl, gr;
        tick(300);
        measure(hl, hr, gl, gr);
        check_eq({tag, "_l"}, hl, el);
        check_eq({tag, "_r"}, hr, er);
        check_eq({tag, "_gl"}, gl, egl);
        check_eq({tag, "_gr"}, gr, egr);
    endtask

    task automatic start_run();
        start_in = 1'b1;
        tick(8);
        start_in = 1'b0;
        tick(2);
        check_eq("start_run", int'(state_o), 1);
    endtask

    initial begin
        logic [15:0] s;
        int e;
        bit seen;

        // Reset with random inputs
        for (int i = 0; i < 5; i++) begin
            sens_in  = 16'($urandom);
            obst_in  = 1'($urandom);
            start_in = 1'($urandom);
            stop_in  = 1'($urandom);
            tick(1);
        end
        check_eq("rst_pwm_l", int'(pwm_l), 0);
        check_eq("rst_pwm_r", int'(pwm_r), 0);
        check_eq("rst_state", int'(state_o), 0);
        check_eq("rst_oeb", int'(out_oeb), 7);
        sens_in = '0; obst_in = 0; start_in = 0; stop_in = 0;
        reset = 1'b1;
        #1;
        check_eq("oeb_pre_edge", int'(out_oeb), 7);
        @(negedge clock);
        check_eq("oeb_post_edge", int'(out_oeb), 0);
        tick(8);
        check_eq("idle_hold", int'(state_o), 0);

        // Straight ahead
        sens_in = 16'h0180;
        start_run();
        settle_check("straight", 128, 128, 128, 128);

        // Turn, then a short glitch that must be filtered
        sens_in = 16'hF000;
        settle_check("err_p4", 96, 160, 0, 255);
        sens_in = 16'h000F;
        tick(3);
        sens_in = 16'hF000;
        tick(20);
        check_eq("glitch_state", int'(state_o), 1);
        settle_check("glitch", 96, 160, 0, 255);

        // Saturation
        sens_in = 16'hFF00;
        settle_check("err_p8", 64, 192, 0, 255);

        // Random patterns
        for (int k = 0; k < 6; k++) begin
            s = 16'($urandom);
            if (s == 16'h0) s = 16'h0001;
            sens_in = s;
            e = ref_err(s);
            settle_check($sformatf("rnd%0d", k),
                         ref_duty(8, e, -1), ref_duty(8, e, 1),
                         ref_duty(32, e, -1), ref_duty(32, e, 1));
            check_eq("rnd_state", int'(state_o), 1);
        end

        // LOST with positive last error, then timeout
        sens_in = 16'hF000;
        tick(20);
        sens_in = 16'h0000;
        tick(6);
        check_eq("lost_pre", int'(state_o), 1);
        tick(1);
        check_eq("lost_entry", int'(state_o), 2);
        settle_check("lost_pos", 0, 128, 0, 128);
        tick(443);
        check_eq("lost_999", int'(state_o), 2);
        tick(1);
        check_eq("lost_timeout", int'(state_o), 0);
        check_eq("lost_timeout_g", int'(g_state), 0);

        // LOST then recovery at cycle 500
        sens_in = 16'hF000;
        start_run();
        tick(20);
        sens_in = 16'h0000;
        tick(7);
        check_eq("lost2_entry", int'(state_o), 2);
        tick(500);
        sens_in = 16'hF000;
        tick(7);
        check_eq("lost2_recover", int'(state_o), 1);

        // LOST with negative last error
        sens_in = 16'h000F;
        tick(20);
        sens_in = 16'h0000;
        tick(7);
        check_eq("lost3_entry", int'(state_o), 2);
        settle_check("lost_neg", 128, 0, 128, 0);
        sens_in = 16'hF000;
        tick(7);
        check_eq("lost3_recover", int'(state_o), 1);

        // Obstacle
        obst_in = 1'b1;
        tick(6);
        check_eq("blk_pre", int'(state_o), 1);
        tick(1);
        check_eq("blk_entry", int'(state_o), 3);
        settle_check("blocked", 0, 0, 0, 0);
        obst_in = 1'b0;
        tick(7);
        check_eq("blk_clear", int'(state_o), 1);

        // Stop wins over obstacle
        obst_in = 1'b1;
        stop_in = 1'b1;
        tick(7);
        check_eq("stop_prio", int'(state_o), 0);
        obst_in = 1'b0;
        stop_in = 1'b0;
        tick(8);

        // Asynchronous reset mid-RUN
        start_run();
        tick(300);
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clock);
            if (pwm_r) seen = 1'b1;
        end
        check_eq("pwm_r_seen", int'(seen), 1);
        reset = 1'b0;
        #1;
        check_eq("arst_pwm_l", int'(pwm_l), 0);
        check_eq("arst_pwm_r", int'(pwm_r), 0);
        check_eq("arst_state", int'(state_o), 0);
        check_eq("arst_oeb", int'(out_oeb), 7);
        tick(3);
        reset = 1'b1;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/oto_pilot_pwm.md
Name: oto_pilot_pwm

Overview:
Parametrised second-generation line-following autopilot core.
- Inputs: a SENS_W-bit line-sensor array plus obstacle, start and stop inputs. All are synchronised and debounced.
- Steering: computes a signed left/right steering error and drives left and right motor PWM outputs.
- Sequencing: a run/lost/blocked state machine.
- Placement: instantiated in the user project wrapper between GPIO inputs and GPIO outputs/oeb.

Parameters:
SENS_W, 16, sensor array width (even, 4..32)
PWM_W, 8, PWM counter and duty width
DEB_CYC, 4, consecutive equal samples needed to accept a new input level (1..15)
LOST_TIMEOUT, 1000, cycles in LOST before giving up to IDLE (1..2^20-1)
BASE_DUTY, 128, straight-ahead duty (< 2^PWM_W)
GAIN, 8, duty change per unit of steering error

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
sens_in  in  SENS_W  raw line sensors; bit SENS_W-1 is leftmost
obst_in  in  1  raw obstacle detect, 1 = blocked
start_in  in  1  raw start request
stop_in  in  1  raw stop request
pwm_l  out  1  left motor PWM
pwm_r  out  1  right motor PWM
state_o  out  2  FSM state: IDLE=0, RUN=1, LOST=2, BLOCKED=3
out_oeb  out  3  pad output-enable bar for {state_o[0], pwm_r, pwm_l}

Behaviour:
- Reset (reset=0): pwm_l=0, pwm_r=0, state_o=0, out_oeb=3'b111. Also cleared: all counters, the PWM counter, duties, the last-error register and debounce state (filtered value 0). Reset applies immediately, including mid-RUN.
- out_oeb register: goes to 3'b000 on the first clock edge after reset deasserts and stays 0.
- Input conditioning:
  - Each bit passes a 2-flop synchroniser.
  - A per-bit debounce counter then changes the filtered value only after DEB_CYC consecutive samples that differ from it.
  - A pulse shorter than DEB_CYC cycles is ignored.
- Error calculation:
  - err = popcount(upper half of filtered sensors) - popcount(lower half).
  - Signed; range -SENS_W/2..+SENS_W/2; registered one cycle after the filtered value changes.
- Steering:
  - tgt_l = sat(BASE_DUTY - GAIN*err); tgt_r = sat(BASE_DUTY + GAIN*err).
  - sat clamps to 0..2^PWM_W-1. Intermediates use signed width PWM_W+clog2(SENS_W)+clog2(GAIN)+2, so no overflow before clamping.
- PWM generation:
  - Free-running PWM_W-bit counter wraps from 2^PWM_W-1 to 0.
  - pwm_x = (cnt < duty_x), registered.
  - Duty 0 gives constant low; duty 2^PWM_W-1 gives high for all but one cycle.
  - duty_l/duty_r load from the FSM-selected targets only in the cycle where cnt==2^PWM_W-1, so no mid-period glitches.
- State machine: transitions are evaluated on filtered inputs, with priority stop > obstacle > lost > normal.
  - IDLE: targets 0/0. Go to RUN when start=1 and stop=0.
  - RUN: targets tgt_l/tgt_r; last_err<=err each cycle. obst=1 goes to BLOCKED; all sensors 0 goes to LOST and clears the lost counter.
  - LOST: pivot toward the last known line. If last_err>=0, targets are l=0, r=BASE_DUTY; otherwise l=BASE_DUTY, r=0. The lost counter increments each cycle.
    - Any sensor set goes to RUN.
    - Counter reaching LOST_TIMEOUT-1 goes to IDLE.
    - obst=1 goes to BLOCKED.
  - BLOCKED: targets 0/0. obst=0 goes to RUN if any sensor is set, otherwise LOST.
  - stop=1 in any state goes to IDLE the next cycle, even when simultaneous with start or obst.
- Latency: raw sensor edge to target update is 2 (sync) + DEB_CYC + 1 cycles. The target reaches the pin at the next PWM wrap, plus 1 cycle.
- state_o is the registered FSM state.

Decomposition:
- Package oto_pilot_pkg holds:
  - the state enum and its 2-bit encoding;
  - a saturation function;
  - a popcount function;
  - the default parameter constants.
- Sub-module oto_pilot_debounce: a synchroniser plus debounce for a WIDTH-bit bus, parameter DEB_CYC. It is instantiated once for sens_in and once for {obst, start, stop}.

Test Plan:
All scenarios use the default parameters unless stated otherwise.
1. Hold reset=0 for 5 cycles with random inputs -> pwm_l=pwm_r=0, state_o=0, out_oeb=3'b111. Release reset -> out_oeb=3'b000 after 1 edge.
2. start_in=1 for 8 cycles with sens_in=16'h0180 -> state_o=1. From the next wrap, duty_l=duty_r=128: each pin is high exactly 128 of every 256 cycles.
3. In RUN, sens_in=16'hF000 (err=+4) -> after the next wrap, pwm_l is high 96/256 and pwm_r 160/256. A 3-cycle glitch to 16'h000F produces no change.
4. With GAIN=32 and sens_in=16'hFF00 (err=+8) -> duty_l=0 (constant low) and duty_r=255 (low 1 cycle per period): saturation, no wrap-around.
5. Two LOST cases:
   - sens_in=0 after err=+4 -> state_o=2, pwm_l=0, pwm_r at 128/256. state_o=0 exactly LOST_TIMEOUT cycles after entry.
   - Repeat with sensors returning at cycle 500 -> state_o=1.
6. Priority and reset:
   - obst_in=1 in RUN -> state_o=3, both PWM low after the wrap. Clearing obst with sensors set -> state_o=1.
   - obst_in and stop_in asserted the same cycle -> state_o=0.
   - reset=0 mid-RUN -> outputs go to reset values asynchronously.
